ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the EX-stage ALU in the pipelined RISC-V core.
- Registers the ALU result and the store data, destination register and WB/MEM control bits.
- Runs the data-memory req/ack handshake for loads and stores.
- Asserts busy_o to freeze upstream stages until memory acknowledges; MEM/WB samples this block's outputs whenever busy_o is low.

Parameters:
- DATA_W, 32, width of ALU result, store data and load data.
- REG_AW, 5, width of destination register address.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-low.
- stall_i  input  1  hazard unit: hold register contents.
- flush_i  input  1  insert bubble instead of EX instruction.
- ex_valid_i  input  1  EX stage holds a real instruction.
- alu_result_i  input  DATA_W  ALU data_o.
- rs2_data_i  input  DATA_W  store data (forwarded rs2).
- rd_i  input  REG_AW  destination register.
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  input  1 each  control bits.
- mem_valid_o  output  1  registered valid.
- alu_result_o  output  DATA_W  registered ALU result; also memory address.
- rd_o  output  REG_AW  registered rd.
- RegWrite_o, MemtoReg_o  output  1 each  registered WB controls.
- dmem_req_o  output  1  memory request, registered.
- dmem_we_o  output  1  1 = store, 0 = load.
- dmem_addr_o  output  DATA_W  equals alu_result_o.
- dmem_wdata_o  output  DATA_W  registered rs2 data.
- dmem_ack_i  input  1  memory completes the request this cycle.
- dmem_rdata_i  input  DATA_W  load data, valid with ack.
- load_data_o  output  DATA_W  latched load data.
- busy_o  output  1  memory op outstanding; freezes PC, IF/ID, ID/EX and this register.

Behaviour:
- Reset (async, rst_i=0):
  - All registered outputs 0 immediately; FSM to IDLE.
  - An outstanding dmem_req_o drops immediately and its ack is ignored.
- Capture enable: cap = !busy_o && !stall_i.
  - On a rising edge with cap and flush_i=1: mem_valid_o=0 and all control bits 0. Data fields may load or hold; they are don't-care.
  - On a rising edge with cap and flush_i=0: all fields load; mem_valid_o=ex_valid_i. Control bits are ANDed with ex_valid_i.
  - Without cap, everything holds. flush_i has no effect while busy_o=1 or stall_i=1.
- FSM states IDLE, REQ, DONE:
  - IDLE/DONE, on a capture of a valid op with MemRead|MemWrite: next state REQ. dmem_req_o=1 from the following cycle; dmem_we_o=MemWrite.
  - IDLE/DONE, on any other capture: next state IDLE.
  - REQ: dmem_req_o held at 1 with stable address, data and we until a cycle with dmem_ack_i=1. At that edge: dmem_req_o to 0; if a load, load_data_o <= dmem_rdata_i; next state DONE.
  - DONE: same as IDLE, but load_data_o is held until the next capture.
- busy_o = (state==REQ), combinational from state.
- Minimum occupancy of a memory op: 2 cycles (capture edge, then ack cycle). Each additional wait cycle adds 1.
- Non-memory ops occupy 1 cycle, no bubble.
- MemRead and MemWrite both set: treated as store; no load data is latched.
- dmem_ack_i outside REQ: ignored.
- load_data_o holds its previous value for non-load instructions.

Optional Feature:
- Macro: EX_MEM_MISALIGN_TRAP_EN.
- Defined: a captured valid load/store with alu_result_i[1:0]!=0 does not enter REQ. Instead:
  - extra output misalign_o is 1 for that instruction's occupancy;
  - RegWrite_o forced 0;
  - busy_o stays 0.
- Undefined: no misalign_o port; the address is passed through unchecked.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and REG_AW;
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - a ctrl_t bundle grouping RegWrite/MemtoReg/MemRead/MemWrite.
- Sub-module ex_mem_dmem_fsm: owns state, dmem_req_o, busy_o and the load_data_o latch. The top holds the pipeline register.

Test Plan:
- Reset mid-REQ: assert rst_i=0 while dmem_req_o=1 -> dmem_req_o, busy_o and mem_valid_o are 0 in the same cycle; state IDLE after release.
- ADD, alu_result_i=0x0000_0010, rd_i=5, RegWrite_i=1 -> next cycle alu_result_o=0x10, rd_o=5, RegWrite_o=1, busy_o=0, dmem_req_o=0.
- Load to 0x40, ack after 3 wait cycles with rdata=0xDEAD_BEEF:
  - busy_o high for 4 cycles;
  - load_data_o=0xDEAD_BEEF after the ack edge;
  - upstream inputs changed during busy are not captured.
- Store of 0x1234_5678 to 0x44, ack in the first REQ cycle -> dmem_we_o=1, dmem_wdata_o=0x1234_5678, busy_o high exactly 1 cycle, load_data_o unchanged.
- flush_i=1 with a valid MemWrite instruction -> mem_valid_o=0, MemWrite not issued, dmem_req_o stays 0. stall_i=1 together with the same inputs -> previous contents held.
- With EX_MEM_MISALIGN_TRAP_EN: load at 0x42 -> misalign_o=1, dmem_req_o=0, RegWrite_o=0, busy_o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined RISC-V core: datapath widths,
// the EX/MEM data-memory FSM encoding and the pipeline control-bit bundle.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    function automatic logic is_mem_op(input ctrl_t c);
        return c.mem_read | c.mem_write;
    endfunction

    // Stores win when both memory bits are set, so only a pure read is a load.
    function automatic logic is_load_op(input ctrl_t c);
        return c.mem_read & ~c.mem_write;
    endfunction

endpackage

// File: rtl/ex_mem_dmem_fsm.sv
// Data-memory handshake for the EX/MEM stage: owns the IDLE/REQ/DONE state,
// the registered request, busy and the load-data latch.
module ex_mem_dmem_fsm
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DATA_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cap_i,
    input  logic          start_i,
    input  logic          load_i,
    input  logic          ack_i,
    input  logic [DW-1:0] rdata_i,
    output logic          req_o,
    output logic          busy_o,
    output logic [DW-1:0] load_data_o,
    output logic [1:0]    state_o
);

    mem_state_e    state_q, state_d;
    logic          req_q, req_d;
    logic [DW-1:0] load_data_q, load_data_d;

    // Handshake: req_o stays high with stable address/data/we until a cycle
    // with ack_i high; that edge completes the transfer. ack_i outside REQ
    // is ignored.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        load_data_d = load_data_q;
        unique case (state_q)
            ST_REQ: begin
                if (ack_i) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (load_i) begin
                        load_data_d = rdata_i;
                    end
                end
            end
            default: begin
                if (start_i) begin
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else if (cap_i) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            load_data_q <= load_data_d;
        end
    end

    assign req_o       = req_q;
    assign busy_o      = (state_q == ST_REQ);
    assign load_data_o = load_data_q;
    assign state_o     = state_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data-memory handshake. Optional misaligned
// load/store trap is enabled by defining EX_MEM_MISALIGN_TRAP_EN.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DATA_W,
    parameter int AW = cpu_pkg::REG_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          ex_valid_i,
    input  logic [DW-1:0] alu_result_i,
    input  logic [DW-1:0] rs2_data_i,
    input  logic [AW-1:0] rd_i,
    input  logic          RegWrite_i,
    input  logic          MemtoReg_i,
    input  logic          MemRead_i,
    input  logic          MemWrite_i,
    output logic          mem_valid_o,
    output logic [DW-1:0] alu_result_o,
    output logic [AW-1:0] rd_o,
    output logic          RegWrite_o,
    output logic          MemtoReg_o,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [DW-1:0] dmem_addr_o,
    output logic [DW-1:0] dmem_wdata_o,
    input  logic          dmem_ack_i,
    input  logic [DW-1:0] dmem_rdata_i,
    output logic [DW-1:0] load_data_o,
    output logic          busy_o,
`ifdef EX_MEM_MISALIGN_TRAP_EN
    output logic          misalign_o,
`endif
    output logic [1:0]    dbg_state_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] alu_q, alu_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] rd_q, rd_d;
    ctrl_t         ctrl_q, ctrl_d;
    ctrl_t         ctrl_in;
    logic          cap;
    logic          mis_in;
    logic          mem_start;
    logic          busy;
`ifdef EX_MEM_MISALIGN_TRAP_EN
    logic          mis_q, mis_d;
`endif

    assign cap = !busy && !stall_i;

`ifdef EX_MEM_MISALIGN_TRAP_EN
    assign mis_in = ex_valid_i && (MemRead_i || MemWrite_i) && (alu_result_i[1:0] != 2'b00);
`else
    assign mis_in = 1'b0;
`endif

    // Control bits of a non-instruction never reach WB or memory; a trapped
    // misaligned access must not write back either.
    always_comb begin
        ctrl_in.reg_write  = RegWrite_i & ex_valid_i & ~mis_in;
        ctrl_in.mem_to_reg = MemtoReg_i & ex_valid_i;
        ctrl_in.mem_read   = MemRead_i  & ex_valid_i;
        ctrl_in.mem_write  = MemWrite_i & ex_valid_i;
    end

    assign mem_start = cap && !flush_i && is_mem_op(ctrl_in) && !mis_in;

    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
`ifdef EX_MEM_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        if (cap) begin
            alu_d   = alu_result_i;
            wdata_d = rs2_data_i;
            rd_d    = rd_i;
            if (flush_i) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
`ifdef EX_MEM_MISALIGN_TRAP_EN
                mis_d   = 1'b0;
`endif
            end else begin
                valid_d = ex_valid_i;
                ctrl_d  = ctrl_in;
`ifdef EX_MEM_MISALIGN_TRAP_EN
                mis_d   = mis_in;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
`ifdef EX_MEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
`ifdef EX_MEM_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    ex_mem_dmem_fsm #(
        .DW (DW)
    ) u_dmem_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cap_i       (cap),
        .start_i     (mem_start),
        .load_i      (is_load_op(ctrl_q)),
        .ack_i       (dmem_ack_i),
        .rdata_i     (dmem_rdata_i),
        .req_o       (dmem_req_o),
        .busy_o      (busy),
        .load_data_o (load_data_o),
        .state_o     (dbg_state_o)
    );

    assign mem_valid_o  = valid_q;
    assign alu_result_o = alu_q;
    assign rd_o         = rd_q;
    assign RegWrite_o   = ctrl_q.reg_write;
    assign MemtoReg_o   = ctrl_q.mem_to_reg;
    assign dmem_we_o    = ctrl_q.mem_write;
    assign dmem_addr_o  = alu_q;
    assign dmem_wdata_o = wdata_q;
    assign busy_o       = busy;
`ifdef EX_MEM_MISALIGN_TRAP_EN
    assign misalign_o   = mis_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus randomized bench for ex_mem_stage against a transaction-level
// model of the EX/MEM register and its outstanding memory operation.
module tb_ex_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, ex_valid_i;
    logic [31:0] alu_result_i, rs2_data_i, dmem_rdata_i;
    logic [4:0]  rd_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, dmem_ack_i;
    logic        mem_valid_o, RegWrite_o, MemtoReg_o, dmem_req_o, dmem_we_o, busy_o;
    logic [31:0] alu_result_o, dmem_addr_o, dmem_wdata_o, load_data_o;
    logic [4:0]  rd_o;
    logic [1:0]  dbg_state_o;
`ifdef EX_MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: what the next stage should see, plus whether a memory
    // transfer is still outstanding.
    bit          m_valid, m_rw, m_mtr, m_we, m_is_load, m_pending, m_known, m_mis;
    logic [31:0] m_alu, m_wdata, m_load;
    logic [4:0]  m_rd;

    always #5 clk_i = ~clk_i;

    ex_mem_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .ex_valid_i   (ex_valid_i),
        .alu_result_i (alu_result_i),
        .rs2_data_i   (rs2_data_i),
        .rd_i         (rd_i),
        .RegWrite_i   (RegWrite_i),
        .MemtoReg_i   (MemtoReg_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .mem_valid_o  (mem_valid_o),
        .alu_result_o (alu_result_o),
        .rd_o         (rd_o),
        .RegWrite_o   (RegWrite_o),
        .MemtoReg_o   (MemtoReg_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .load_data_o  (load_data_o),
        .busy_o       (busy_o),
`ifdef EX_MEM_MISALIGN_TRAP_EN
        .misalign_o   (misalign_o),
`endif
        .dbg_state_o  (dbg_state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mtr = 0; m_we = 0; m_is_load = 0;
        m_pending = 0; m_known = 1; m_mis = 0;
        m_alu = '0; m_wdata = '0; m_load = '0; m_rd = '0;
    endtask

    task automatic check_all();
        check("mem_valid", {31'b0, mem_valid_o}, {31'b0, m_valid});
        check("regwrite",  {31'b0, RegWrite_o},  {31'b0, m_rw});
        check("memtoreg",  {31'b0, MemtoReg_o},  {31'b0, m_mtr});
        check("dmem_req",  {31'b0, dmem_req_o},  {31'b0, m_pending});
        check("busy",      {31'b0, busy_o},      {31'b0, m_pending});
        check("load_data", load_data_o, m_load);
        if (m_known) begin
            check("alu_result", alu_result_o, m_alu);
            check("dmem_addr",  dmem_addr_o,  m_alu);
            check("rd",         {27'b0, rd_o}, {27'b0, m_rd});
            check("wdata",      dmem_wdata_o, m_wdata);
        end
        if (m_pending) check("dmem_we", {31'b0, dmem_we_o}, {31'b0, m_we});
`ifdef EX_MEM_MISALIGN_TRAP_EN
        check("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
`endif
    endtask

    // Advance one clock: update the model from the inputs present at the
    // edge, then compare shortly after the edge.
    task automatic tick();
        bit mem_op, mis;
        if (!m_pending && !stall_i) begin
            if (flush_i) begin
                m_valid = 0; m_rw = 0; m_mtr = 0; m_we = 0; m_is_load = 0;
                m_mis = 0; m_known = 0;
            end else begin
                mem_op = ex_valid_i && (MemRead_i || MemWrite_i);
`ifdef EX_MEM_MISALIGN_TRAP_EN
                mis = mem_op && (alu_result_i % 4 != 0);
`else
                mis = 0;
`endif
                m_valid   = ex_valid_i;
                m_alu     = alu_result_i;
                m_wdata   = rs2_data_i;
                m_rd      = rd_i;
                m_rw      = RegWrite_i && ex_valid_i && !mis;
                m_mtr     = MemtoReg_i && ex_valid_i;
                m_we      = MemWrite_i && ex_valid_i;
                m_is_load = ex_valid_i && MemRead_i && !MemWrite_i;
                m_pending = mem_op && !mis;
                m_mis     = mis;
                m_known   = 1;
            end
        end else if (m_pending && dmem_ack_i) begin
            m_pending = 0;
            if (m_is_load) m_load = dmem_rdata_i;
        end
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] w,
                         input logic [4:0] r, input bit rw, input bit mtr,
                         input bit mr, input bit mw);
        ex_valid_i = v; alu_result_i = a; rs2_data_i = w; rd_i = r;
        RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
    endtask

    task automatic set_idle();
        drive(0, '0, '0, '0, 0, 0, 0, 0);
        stall_i = 0; flush_i = 0; dmem_ack_i = 0; dmem_rdata_i = '0;
    endtask

    initial begin
        int busy_cnt;
        set_idle();
        model_reset();
        rst_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check_all();
        check("reset_state", {30'b0, dbg_state_o}, 32'd0);
        rst_i = 1;

        // ADD
        drive(1, 32'h0000_0010, 32'h0, 5'd5, 1, 0, 0, 0);
        tick();
        check("add_alu", alu_result_o, 32'h10);
        check("add_rd", {27'b0, rd_o}, 32'd5);

        // Load from 0x40, three wait cycles before ack
        drive(1, 32'h0000_0040, 32'h0, 5'd6, 1, 1, 1, 0);
        tick();
        drive(1, 32'h0000_0999, 32'h5555_5555, 5'd9, 1, 0, 0, 0);
        dmem_rdata_i = 32'hDEAD_BEEF;
        busy_cnt = 0;
        for (int i = 0; i < 10 && busy_o; i++) begin
            busy_cnt++;
            dmem_ack_i = (busy_cnt == 4);
            tick();
        end
        dmem_ack_i = 0;
        check("load_busy_cycles", busy_cnt, 32'd4);
        check("load_data", load_data_o, 32'hDEAD_BEEF);
        check("load_hold_addr", alu_result_o, 32'h40);
        tick();

        // Store to 0x44, ack in first REQ cycle
        drive(1, 32'h0000_0044, 32'h1234_5678, 5'd0, 0, 0, 0, 1);
        tick();
        check("store_we", {31'b0, dmem_we_o}, 32'd1);
        check("store_wdata", dmem_wdata_o, 32'h1234_5678);
        set_idle();
        dmem_ack_i = 1;
        dmem_rdata_i = 32'hBAD0_BAD0;
        tick();
        check("store_busy_one", {31'b0, busy_o}, 32'd0);
        check("store_load_kept", load_data_o, 32'hDEAD_BEEF);
        dmem_ack_i = 0;

        // Flush a valid store
        drive(1, 32'h0000_0048, 32'hAAAA_0000, 5'd3, 0, 0, 0, 1);
        flush_i = 1;
        tick();
        check("flush_no_req", {31'b0, dmem_req_o}, 32'd0);
        flush_i = 0;

        // Stall holds contents
        drive(1, 32'h0000_0077, 32'h0, 5'd7, 1, 0, 0, 0);
        tick();
        drive(1, 32'h0000_0048, 32'hAAAA_0000, 5'd3, 0, 0, 0, 1);
        stall_i = 1;
        tick();
        check("stall_hold_alu", alu_result_o, 32'h77);
        check("stall_no_req", {31'b0, dmem_req_o}, 32'd0);
        stall_i = 0;

`ifdef EX_MEM_MISALIGN_TRAP_EN
        drive(1, 32'h0000_0042, 32'h0, 5'd4, 1, 1, 1, 0);
        tick();
        check("mis_flag", {31'b0, misalign_o}, 32'd1);
        check("mis_no_req", {31'b0, dmem_req_o}, 32'd0);
        set_idle();
        tick();
`endif

        // Reset while a request is outstanding
        drive(1, 32'h0000_0080, 32'h0, 5'd8, 1, 1, 1, 0);
        tick();
        set_idle();
        #2 rst_i = 0;
        #1;
        check("rst_req", {31'b0, dmem_req_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_valid", {31'b0, mem_valid_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1;
        model_reset();
        check("rst_state_idle", {30'b0, dbg_state_o}, 32'd0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            stall_i      = ($urandom_range(0, 4) == 0);
            flush_i      = ($urandom_range(0, 5) == 0);
            dmem_ack_i   = ($urandom_range(0, 2) == 0);
            dmem_rdata_i = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
